// File: rtl/clmul_pkg.sv
// Shared types and the result-word selector for the iterative carry-less multiplier.
// Latency: none (package only).
// Backpressure: not applicable.
package clmul_pkg;

    localparam int CLMUL_XLEN = 32;

    typedef enum logic [1:0] {
        CLMUL  = 2'b00,
        CLMULH = 2'b01,
        CLMULR = 2'b10
    } clmul_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } clmul_state_e;

    // Encoding 2'b11 falls through to the low word, same as clmul.
    function automatic logic [CLMUL_XLEN-1:0] clmul_select(
        input logic [1:0]              op,
        input logic [2*CLMUL_XLEN-1:0] acc
    );
        case (clmul_op_e'(op))
            CLMULH:  return acc[2*CLMUL_XLEN-1:CLMUL_XLEN];
            CLMULR:  return acc[2*CLMUL_XLEN-2:CLMUL_XLEN-1];
            default: return acc[CLMUL_XLEN-1:0];
        endcase
    endfunction

endpackage

// File: rtl/clmul_step.sv
// One iteration of the shift-and-xor carry-less product over BITS_PER_CYCLE multiplier bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module clmul_step
    import clmul_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*CLMUL_XLEN-1:0]  acc_i,
    input  logic [2*CLMUL_XLEN-1:0]  a_sh_i,
    input  logic [BITS_PER_CYCLE-1:0] b_i,
    output logic [2*CLMUL_XLEN-1:0]  acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (b_i[k]) begin
                acc_o = acc_o ^ (a_sh_i << k);
            end
        end
    end

endmodule

// File: rtl/clmul_iter.sv
// Iterative Zbc carry-less multiply (clmul/clmulh/clmulr); CLMUL_ITER_EARLY_EXIT_EN stops once multiplier bits run out.
// Latency: 32/BITS_PER_CYCLE cycles from accept to valid_o (fewer with early exit, min 1).
// Backpressure: result held in DONE until ready_i; ready_o low from accept until handshake; kill_i aborts.
module clmul_iter
    import clmul_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [CLMUL_XLEN-1:0] op_a_i,
    input  logic [CLMUL_XLEN-1:0] op_b_i,
    input  logic [1:0]            operator_i,
    input  logic                  kill_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CLMUL_XLEN-1:0] result_o
);

    localparam int         STEPS    = CLMUL_XLEN / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(STEPS - 1);

    generate
        if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > 8 || (CLMUL_XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
            $error("clmul_iter: BITS_PER_CYCLE must divide 32 and be at most 8");
        end
    endgenerate

    clmul_state_e            state_q, state_d;
    logic [2*CLMUL_XLEN-1:0] a_sh_q, a_sh_d;
    logic [2*CLMUL_XLEN-1:0] acc_q, acc_d;
    logic [CLMUL_XLEN-1:0]   b_sh_q, b_sh_d;
    logic [1:0]              op_q, op_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [CLMUL_XLEN-1:0]   result_q, result_d;

    logic [2*CLMUL_XLEN-1:0] acc_step;
    logic [CLMUL_XLEN-1:0]   b_sh_nxt;
    logic                    last_step;

    clmul_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .acc_i  (acc_q),
        .a_sh_i (a_sh_q),
        .b_i    (b_sh_q[BITS_PER_CYCLE-1:0]),
        .acc_o  (acc_step)
    );

    assign b_sh_nxt = b_sh_q >> BITS_PER_CYCLE;

`ifdef CLMUL_ITER_EARLY_EXIT_EN
    assign last_step = (cnt_q == CNT_LAST) || (b_sh_nxt == '0);
`else
    assign last_step = (cnt_q == CNT_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            acc_q    <= '0;
            b_sh_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            a_sh_q   <= a_sh_d;
            acc_q    <= acc_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // A flush wins over everything and leaves the datapath untouched.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        acc_d    = acc_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_sh_d  = {{CLMUL_XLEN{1'b0}}, op_a_i};
                        b_sh_d  = op_b_i;
                        op_d    = operator_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    acc_d  = acc_step;
                    a_sh_d = a_sh_q << BITS_PER_CYCLE;
                    b_sh_d = b_sh_nxt;
                    cnt_d  = cnt_q + 5'd1;
                    if (last_step) begin
                        result_d = clmul_select(op_q, acc_step);
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    assign result_o = result_q;

endmodule

// File: doc/clmul_iter.md
# clmul_iter

Iterative, multi-cycle carry-less multiply unit for the Zbc extension. It sits in the EX stage beside the ALU and accepts operands and an operation code from ID/EX over a valid/ready handshake. It builds the full 64-bit carry-less product a few bits per cycle and returns the clmul, clmulh or clmulr word to the writeback path over a second valid/ready handshake.

## Interface
- `BITS_PER_CYCLE`, default 1: number of op_b bits consumed per BUSY cycle; legal values 1, 2, 4, 8.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_i` input 1: request valid from ID/EX.
- `ready_o` output 1: unit can accept a request.
- `op_a_i` input 32: multiplicand.
- `op_b_i` input 32: multiplier.
- `operator_i` input 2: 00 clmul, 01 clmulh, 10 clmulr; 11 is treated as clmul.
- `kill_i` input 1: pipeline flush; aborts any operation in flight.
- `valid_o` output 1: result valid toward WB.
- `ready_i` input 1: WB accepts the result.
- `result_o` output 32: selected result word.

## Operation
- FSM states are IDLE, BUSY and DONE; reset enters IDLE.
- **IDLE:** `ready_o`=1. When `valid_i` is high and `kill_i` is low, the unit latches:
  - a_sh = {32'b0, op_a_i}
  - b_sh = op_b_i
  - op = operator_i
  - acc = 0, cnt = 0
  - then moves to BUSY.
- **BUSY:** `ready_o`=0. Each cycle, for k in 0..BITS_PER_CYCLE-1, if b_sh[k] then acc ^= a_sh << k. Then:
  - a_sh <<= BITS_PER_CYCLE
  - b_sh >>= BITS_PER_CYCLE
  - cnt++
  - When cnt reaches 32/BITS_PER_CYCLE-1, move to DONE on that edge.
- On entry to DONE, the result register is loaded:
  - clmul: acc[31:0]
  - clmulh: acc[63:32] (acc[63] is always 0)
  - clmulr: acc[62:31]
- **DONE:** `valid_o`=1 and `result_o` is held stable. When `ready_i` is high, move to IDLE on that edge. `ready_o`=0 throughout DONE, so there is no same-cycle re-accept.
- **kill_i:** highest priority. From any state, the next edge goes to IDLE, `valid_o` drops and no result is produced. `kill_i` together with `valid_i` in IDLE means the request is not accepted.
- **Async reset mid-operation:** state is IDLE immediately; all datapath registers are cleared.
- **Reset values:**
  - `ready_o`=1
  - `valid_o`=0
  - `result_o`=0

## Timing
- Accept edge is E0. Without early exit, `valid_o` rises after edge E(32/BITS_PER_CYCLE): 32 cycles at BPC=1, 8 cycles at BPC=4.
- `valid_o` holds until the edge with `ready_i`=1. The earliest next accept is the cycle after handshake completion.
- Throughput is one operation per latency+2 cycles, assuming `ready_i` is held high.
- `ready_o` and `valid_o` are decoded from state only, with no combinational path from inputs.
- `result_o` comes from a register and never changes while `valid_o`=1.

## Configuration
- Macro `CLMUL_ITER_EARLY_EXIT_EN`.
- **Defined:** in BUSY, the unit also moves to DONE on the edge where next b_sh == 0. Result is unchanged. Latency = max(1, ceil((msb_index(op_b)+1)/BITS_PER_CYCLE)); op_b=0 gives 1 cycle.
- **Undefined:** latency is fixed at 32/BITS_PER_CYCLE cycles for every operand.

## Structure
- Shared package `clmul_pkg` contains:
  - `clmul_op_e` (CLMUL=2'b00, CLMULH=2'b01, CLMULR=2'b10)
  - `clmul_state_e` (IDLE, BUSY, DONE)
  - localparam `CLMUL_XLEN`=32
- One sub-module, `clmul_step`: combinational, takes acc[63:0], a_sh[63:0] and b_sh[BITS_PER_CYCLE-1:0], and returns the next acc. Instantiated once in the BUSY datapath.
- The parameter is checked at elaboration: BITS_PER_CYCLE must divide 32 and be ≤8.

## Test plan
- **clmul basic:** a=0x00000003, b=0x00000005, op=00 -> result 0x0000000F; BPC=1 without macro: `valid_o` 32 cycles after accept.
- **clmulh/clmulr:** a=0x80000000, b=0x80000000 -> clmulh 0x40000000; clmulr 0x80000000; all-ones a=b=0xFFFFFFFF with clmul -> 0x55555555.
- **Backpressure:** hold `ready_i`=0 for 10 cycles in DONE with `valid_i`=1 and new operands -> `result_o` stable, `ready_o`=0, new request accepted only after handshake; the second result is correct.
- **Flush:** `kill_i` on the 5th BUSY cycle -> IDLE next cycle, `valid_o` never asserts; `kill_i`+`valid_i` in IDLE -> no accept; the following op a=0x12345678, b=0x1, op=00 -> 0x12345678.
- **Early exit (macro defined):** b=0x00000001 -> `valid_o` 1 cycle after accept; b=0 -> result 0 after 1 cycle; without macro, both take 32 cycles at BPC=1.
- **Reset:** `rst_n` low mid-BUSY -> immediately `ready_o`=1, `valid_o`=0, `result_o`=0; the next op runs correctly; repeat all cases at BPC=4 (8-cycle latency).
